model_driver: RTL
=================

Name: model_driver

Overview:
- Host-side initiator for the inference model interface; it is the other end of the model's `in_data`/`in_valid` → `out_data`/`out_ready` protocol.
- Accepts a serial stream of input words and packs IN_DIM words into a vector. Issues the vector to the model with a one-cycle `in_valid` pulse.
- Waits for the model's `out_ready` pulse and captures `out_data`, then serializes OUT_DIM result words back to the host.
- Sits between the testbench/host word stream and any `model` instance. Provides a timeout, an inference counter and a busy status.

Parameters:
- IN_W, 32, width of one model input element
- IN_DIM, 1, number of input elements per inference (≥1)
- OUT_W, 32, width of one model output element
- OUT_DIM, 1, number of output elements per inference (≥1)
- TIMEOUT, 1024, maximum cycles spent in WAIT before aborting (≥1)

Ports:
- clk  input  1  clock; all logic is on the rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- s_data  input  IN_W  host input word
- s_valid  input  1  host input word valid
- s_ready  output  1  driver can accept an input word
- in_data  output  IN_W x [0:IN_DIM-1]  vector to the model
- in_valid  output  1  one-cycle issue pulse to the model
- out_data  input  OUT_W x [0:OUT_DIM-1]  model result vector
- out_ready  input  1  model result-valid pulse
- m_data  output  OUT_W  result word to the host
- m_valid  output  1  result word valid
- m_ready  input  1  host accepts the result word
- busy  output  1  high in any state except LOAD with zero words loaded
- timeout_err  output  1  sticky; set on a WAIT timeout, cleared only by reset
- infer_count  output  16  completed inferences; wraps from 0xFFFF to 0

Behaviour:
- Reset (reset=0, asynchronous):
  - state=LOAD; load index, drain index and timeout counter = 0.
  - `in_data` elements = 0; `in_valid`, `s_ready`, `m_valid`, `busy`, `timeout_err` = 0; `m_data` = 0; `infer_count` = 0.
  - Reset mid-operation discards any partial vector or results. No `in_valid` is emitted after reset is released until a full vector has been loaded again.
- LOAD:
  - `s_ready`=1.
  - Each cycle with `s_valid`&&`s_ready` writes `s_data` to `in_data[idx]` and increments idx.
  - When the word at idx=IN_DIM-1 is accepted, go to ISSUE and clear idx.
- ISSUE:
  - Lasts exactly one cycle: `in_valid`=1, `s_ready`=0; `in_data` is held stable.
  - Next state is WAIT with the timeout counter = 0.
  - Minimum latency from the last accepted input word to `in_valid` high is 1 cycle.
- WAIT:
  - `in_data` is held. The timeout counter increments each cycle.
  - `out_ready`=1 sampled: capture all `out_data` elements into an internal buffer, increment `infer_count`, go to DRAIN.
  - `out_ready` asserted in the same cycle as `in_valid` (ISSUE) is ignored; only WAIT samples `out_ready`.
  - Counter reaches TIMEOUT-1 with no `out_ready`: set `timeout_err`, emit no results, go to LOAD. `infer_count` is unchanged.
  - `out_ready` and timeout in the same cycle: `out_ready` wins.
- DRAIN:
  - `m_valid`=1, `m_data`=buffer[didx].
  - On `m_valid`&&`m_ready`, didx increments. Accepting the word at didx=OUT_DIM-1 returns the block to LOAD.
  - `m_data` and `m_valid` are stable while `m_ready`=0; they may be held indefinitely.
  - `m_ready` is ignored outside DRAIN.
- `out_ready` outside WAIT is ignored; no capture occurs.
- Width rules: no arithmetic on data; data is stored and forwarded bit-exact. idx/didx widths are clog2 of the respective DIM, minimum 1 bit.

Test Plan:
- IN_DIM=2, OUT_DIM=3: send s_data=0x11,0x22 → one `in_valid` pulse with in_data={0x11,0x22}. Model returns {0xA,0xB,0xC} after 4 cycles → m_data 0xA,0xB,0xC in order; infer_count=1.
- Backpressure: m_ready toggles 0/1 every cycle during DRAIN → each result word is held stable while m_ready=0; exactly 3 handshakes occur; s_ready stays 0 until the last one.
- Timeout: TIMEOUT=8 and the model never asserts out_ready → timeout_err=1 in the 8th WAIT cycle, return to LOAD, no m_valid, infer_count unchanged. A following good inference still completes with timeout_err remaining 1.
- Reset mid-operation: pull reset low after 1 of 2 input words → all outputs go to 0 immediately (asynchronously). After release, two new words produce exactly one in_valid containing the new values only.
- Stray out_ready: pulse out_ready during LOAD and during ISSUE → no capture, no m_valid, infer_count unchanged.
- Counter wrap: preload or run 65536 inferences → infer_count returns to 0 with no other side effects.

Source files
------------

// File: rtl/model_driver.sv
// Host-side initiator for the inference model: packs host words into a vector,
// issues it with a one-cycle pulse, waits for the result and streams it back.
module model_driver #(
  parameter int IN_W    = 32,
  parameter int IN_DIM  = 1,
  parameter int OUT_W   = 32,
  parameter int OUT_DIM = 1,
  parameter int TIMEOUT = 1024
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [IN_W-1:0]                  s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [0:IN_DIM-1][IN_W-1:0]      in_data,
  output logic                             in_valid,
  input  logic [0:OUT_DIM-1][OUT_W-1:0]    out_data,
  input  logic                             out_ready,
  output logic [OUT_W-1:0]                 m_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic                             busy,
  output logic                             timeout_err,
  output logic [15:0]                      infer_count
);

  localparam int LD_W = (IN_DIM  > 1) ? $clog2(IN_DIM)  : 1;
  localparam int DR_W = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1;
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [LD_W-1:0] LD_LAST = LD_W'(IN_DIM - 1);
  localparam logic [DR_W-1:0] DR_LAST = DR_W'(OUT_DIM - 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t                            r_state;
  state_t                            w_state_next;
  logic                              r_armed;
  logic [LD_W-1:0]                   r_idx;
  logic [DR_W-1:0]                   r_didx;
  logic [TO_W-1:0]                   r_tcnt;
  logic [0:IN_DIM-1][IN_W-1:0]       r_in_vec;
  logic [0:OUT_DIM-1][OUT_W-1:0]     r_obuf;
  logic                              r_terr;
  logic [15:0]                       r_cnt;

  logic w_s_fire;
  logic w_m_fire;
  logic w_load_done;
  logic w_drain_done;
  logic w_capture;
  logic w_expire;

  assign w_s_fire     = s_valid && s_ready;
  assign w_m_fire     = m_valid && m_ready;
  assign w_load_done  = w_s_fire && (r_idx == LD_LAST);
  assign w_drain_done = w_m_fire && (r_didx == DR_LAST);
  assign w_capture    = (r_state == ST_WAIT) && out_ready;
  // out_ready wins over an expiry landing in the same cycle
  assign w_expire     = (r_state == ST_WAIT) && !out_ready && (r_tcnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_LOAD;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_LOAD:  if (w_load_done)  w_state_next = ST_ISSUE;
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        if (out_ready)     w_state_next = ST_DRAIN;
        else if (w_expire) w_state_next = ST_LOAD;
      end
      ST_DRAIN: if (w_drain_done) w_state_next = ST_LOAD;
      default:  w_state_next = ST_LOAD;
    endcase
  end

  // r_armed keeps s_ready low while reset is held, even though the state is LOAD
  always_comb begin
    s_ready  = (r_state == ST_LOAD) && r_armed;
    in_valid = (r_state == ST_ISSUE);
    m_valid  = (r_state == ST_DRAIN);
    busy     = !((r_state == ST_LOAD) && (r_idx == '0));
  end

  always_comb begin
    m_data = '0;
    for (int i = 0; i < OUT_DIM; i++) begin
      if (r_didx == DR_W'(i)) m_data = r_obuf[i];
    end
  end

  assign in_data     = r_in_vec;
  assign timeout_err = r_terr;
  assign infer_count = r_cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_armed <= 1'b0;
      r_idx   <= '0;
      r_didx  <= '0;
      r_tcnt  <= '0;
      r_terr  <= 1'b0;
      r_cnt   <= 16'd0;
    end else begin
      r_armed <= 1'b1;
      if (w_s_fire) begin
        r_idx <= w_load_done ? '0 : r_idx + LD_W'(1);
      end
      if (w_m_fire) begin
        r_didx <= w_drain_done ? '0 : r_didx + DR_W'(1);
      end
      if (r_state == ST_ISSUE) begin
        r_tcnt <= '0;
      end else if (r_state == ST_WAIT) begin
        r_tcnt <= r_tcnt + TO_W'(1);
      end
      if (w_expire) begin
        r_terr <= 1'b1;
      end
      if (w_capture) begin
        r_cnt <= r_cnt + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_in_vec <= '0;
      r_obuf   <= '0;
    end else begin
      for (int i = 0; i < IN_DIM; i++) begin
        if (w_s_fire && (r_idx == LD_W'(i))) r_in_vec[i] <= s_data;
      end
      if (w_capture) begin
        r_obuf <= out_data;
      end
    end
  end

endmodule
